// File: rtl/reset_seq.sv
// reset_seq: reset sequencer feeding the per-domain reset_pipe synchronizers.
// Holds every domain in reset for HOLD_CYCLES edges after power-on or after a
// software/watchdog request, then releases domains 0..NUM_DOMAINS-1 one at a
// time, STAGE_GAP edges apart, and finally raises rst_done.
// Optional: define RESET_SEQ_CAUSE_EN to add the registered rst_cause output.
module reset_seq #(
  parameter int NUM_DOMAINS = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4
) (
  input  logic                   clk,
  input  logic                   async_in_rst,
  input  logic                   sw_rst_req,
  input  logic                   wdt_rst_req,
  output logic [NUM_DOMAINS-1:0] rst_out_n,
  output logic                   rst_done,
  output logic                   busy
`ifdef RESET_SEQ_CAUSE_EN
  ,
  output logic [1:0]             rst_cause
`endif
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  // Terminal compare values: the edge that moves the counter onto the
  // target count is the edge that performs the release.
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] CNT_TOP   = CW'(CNT_MAX);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STAGGER = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          counter_q, counter_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_out_n_q, rst_out_n_d;
  logic                   rst_done_q, rst_done_d;

  logic          req;
  logic          hold_done;
  logic          gap_done;
  logic [CW-1:0] cnt_inc;

  assign req       = sw_rst_req | wdt_rst_req;
  assign hold_done = (counter_q == HOLD_LAST);
  assign gap_done  = (counter_q == GAP_LAST);
  // Saturating increment: the counter never wraps.
  assign cnt_inc   = (counter_q == CNT_TOP) ? counter_q : counter_q + CW'(1);

  // State and datapath registers; async_in_rst forces the full-reset state at once.
  always_ff @(posedge clk or negedge async_in_rst) begin
    if (!async_in_rst) begin
      state_q     <= ST_HOLD;
      counter_q   <= '0;
      idx_q       <= '0;
      rst_out_n_q <= '0;
      rst_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      idx_q       <= idx_d;
      rst_out_n_q <= rst_out_n_d;
      rst_done_q  <= rst_done_d;
    end
  end

  // Next-state logic; a request from any state returns to HOLD.
  always_comb begin
    state_d = state_q;
    if (req) begin
      state_d = ST_HOLD;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_done) state_d = (NUM_DOMAINS == 1) ? ST_RUN : ST_STAGGER;
        end
        ST_STAGGER: begin
          if (gap_done && (idx_q == IDX_LAST)) state_d = ST_RUN;
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_HOLD;
      endcase
    end
  end

  // Counter, release index and output values; a request overrides any release.
  always_comb begin
    counter_d   = counter_q;
    idx_d       = idx_q;
    rst_out_n_d = rst_out_n_q;
    rst_done_d  = rst_done_q;
    if (req) begin
      counter_d   = '0;
      idx_d       = '0;
      rst_out_n_d = '0;
      rst_done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_done) begin
            counter_d   = '0;
            rst_out_n_d = rst_out_n_q | NUM_DOMAINS'(1);
            idx_d       = (NUM_DOMAINS == 1) ? '0 : IW'(1);
            rst_done_d  = (NUM_DOMAINS == 1);
          end else begin
            counter_d = cnt_inc;
          end
        end
        ST_STAGGER: begin
          if (gap_done) begin
            counter_d   = '0;
            rst_out_n_d = rst_out_n_q | (NUM_DOMAINS'(1) << idx_q);
            if (idx_q == IDX_LAST) rst_done_d = 1'b1;
            else                   idx_d      = idx_q + IW'(1);
          end else begin
            counter_d = cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign rst_out_n = rst_out_n_q;
  assign rst_done  = rst_done_q;
  assign busy      = ~rst_done_q;

`ifdef RESET_SEQ_CAUSE_EN
  logic [1:0] rst_cause_q, rst_cause_d;

  // Cause of the most recent request; only async_in_rst returns it to power-on.
  always_comb begin
    rst_cause_d = rst_cause_q;
    if (req) rst_cause_d = {wdt_rst_req, sw_rst_req};
  end

  // Cause register.
  always_ff @(posedge clk or negedge async_in_rst) begin
    if (!async_in_rst) rst_cause_q <= 2'b00;
    else               rst_cause_q <= rst_cause_d;
  end

  assign rst_cause = rst_cause_q;
`endif

endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: directed scenarios plus randomized requests/resets against a
// model that tracks "edges since the last request or reset" and derives each
// output from the release schedule HOLD + k*GAP.
`timescale 1ns/1ps
module tb_reset_seq;

  localparam int N_A = 3, H_A = 16, G_A = 4;
  localparam int N_B = 1, H_B = 1,  G_B = 4;
  localparam int E_LIMIT = 1000;

  logic clk = 1'b0;
  logic async_in_rst = 1'b1;
  logic sw_rst_req = 1'b0;
  logic wdt_rst_req = 1'b0;

  logic [N_A-1:0] out_a;
  logic           done_a, busy_a;
  logic [N_B-1:0] out_b;
  logic           done_b, busy_b;
`ifdef RESET_SEQ_CAUSE_EN
  logic [1:0] cause_a, cause_b;
`endif

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model state: edges since timing last restarted, and last request cause.
  int         e_m = 0;
  logic [1:0] cause_m = 2'b00;

  reset_seq #(.NUM_DOMAINS(N_A), .HOLD_CYCLES(H_A), .STAGE_GAP(G_A)) dut_a (
    .clk(clk), .async_in_rst(async_in_rst), .sw_rst_req(sw_rst_req),
    .wdt_rst_req(wdt_rst_req), .rst_out_n(out_a), .rst_done(done_a), .busy(busy_a)
`ifdef RESET_SEQ_CAUSE_EN
    , .rst_cause(cause_a)
`endif
  );

  reset_seq #(.NUM_DOMAINS(N_B), .HOLD_CYCLES(H_B), .STAGE_GAP(G_B)) dut_b (
    .clk(clk), .async_in_rst(async_in_rst), .sw_rst_req(sw_rst_req),
    .wdt_rst_req(wdt_rst_req), .rst_out_n(out_b), .rst_done(done_b), .busy(busy_b)
`ifdef RESET_SEQ_CAUSE_EN
    , .rst_cause(cause_b)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_out(int e, int n, int h, int g);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k] = (e >= h + k * g);
    return r;
  endfunction

  function automatic logic exp_done(int e, int n, int h, int g);
    return (e >= h + (n - 1) * g);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a request edge or async reset restarts the count.
  always @(posedge clk or negedge async_in_rst) begin
    if (!async_in_rst) begin
      e_m     <= 0;
      cause_m <= 2'b00;
    end else if (sw_rst_req || wdt_rst_req) begin
      e_m     <= 0;
      cause_m <= {wdt_rst_req, sw_rst_req};
    end else if (e_m < E_LIMIT) begin
      e_m <= e_m + 1;
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("a_rst_out_n", 32'(out_a), exp_out(e_m, N_A, H_A, G_A));
      chk("a_rst_done", 32'(done_a), 32'(exp_done(e_m, N_A, H_A, G_A)));
      chk("a_busy", 32'(busy_a), 32'(!exp_done(e_m, N_A, H_A, G_A)));
      chk("b_rst_out_n", 32'(out_b), exp_out(e_m, N_B, H_B, G_B));
      chk("b_rst_done", 32'(done_b), 32'(exp_done(e_m, N_B, H_B, G_B)));
      chk("b_busy", 32'(busy_b), 32'(!exp_done(e_m, N_B, H_B, G_B)));
`ifdef RESET_SEQ_CAUSE_EN
      chk("a_cause", 32'(cause_a), 32'(cause_m));
      chk("b_cause", 32'(cause_b), 32'(cause_m));
`endif
    end
  end

  initial begin
    // Power-on with defaults.
    #1 async_in_rst = 1'b0;
    #1 check_en = 1'b1;
    repeat (3) step();
    chk("por_out_in_reset", 32'(out_a), 32'h0);
    chk("por_busy_in_reset", 32'(busy_a), 32'h1);
    async_in_rst = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (i == 1)  chk("por_b_out_e1", 32'(out_b), 32'h1);
      if (i == 1)  chk("por_b_done_e1", 32'(done_b), 32'h1);
      if (i == 15) chk("por_out_e15", 32'(out_a), 32'h0);
      if (i == 16) chk("por_out_e16", 32'(out_a), 32'h1);
      if (i == 19) chk("por_out_e19", 32'(out_a), 32'h1);
      if (i == 20) chk("por_out_e20", 32'(out_a), 32'h3);
      if (i == 23) chk("por_done_e23", 32'(done_a), 32'h0);
      if (i == 24) chk("por_out_e24", 32'(out_a), 32'h7);
      if (i == 24) chk("por_done_e24", 32'(done_a), 32'h1);
      if (i == 24) chk("por_busy_e24", 32'(busy_a), 32'h0);
    end
    $display("power-on sequence done at %0t", $time);
    repeat (5) step();

    // Asynchronous assertion in RUN, 3ns after an edge.
    #2 async_in_rst = 1'b0;
    #1;
    chk("async_out", 32'(out_a), 32'h0);
    chk("async_done", 32'(done_a), 32'h0);
    chk("async_busy", 32'(busy_a), 32'h1);
    chk("async_b_out", 32'(out_b), 32'h0);
`ifdef RESET_SEQ_CAUSE_EN
    chk("async_cause", 32'(cause_a), 32'h0);
`endif
    step();
    async_in_rst = 1'b1;
    repeat (30) step();
    $display("async reset in RUN done at %0t", $time);

    // Software pulse in RUN.
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    chk("sw_out_p", 32'(out_a), 32'h0);
    chk("sw_b_out_p", 32'(out_b), 32'h0);
    for (int n = 1; n <= 24; n++) begin
      step();
      if (n == 1)  chk("sw_b_out_p1", 32'(out_b), 32'h1);
      if (n == 15) chk("sw_out_p15", 32'(out_a), 32'h0);
      if (n == 16) chk("sw_out_p16", 32'(out_a), 32'h1);
      if (n == 20) chk("sw_out_p20", 32'(out_a), 32'h3);
      if (n == 24) chk("sw_out_p24", 32'(out_a), 32'h7);
      if (n == 24) chk("sw_done_p24", 32'(done_a), 32'h1);
`ifdef RESET_SEQ_CAUSE_EN
      if (n == 24) chk("sw_cause", 32'(cause_a), 32'h1);
`endif
    end
    $display("software request sequence done at %0t", $time);

    // Watchdog pulse coincident with the domain-1 release edge.
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    for (int n = 1; n <= 19; n++) step();
    wdt_rst_req = 1'b1;
    step();
    wdt_rst_req = 1'b0;
    chk("wdt_coincident_out", 32'(out_a), 32'h0);
    chk("wdt_coincident_done", 32'(done_a), 32'h0);
`ifdef RESET_SEQ_CAUSE_EN
    chk("wdt_cause", 32'(cause_a), 32'h2);
`endif
    for (int n = 1; n <= 24; n++) begin
      step();
      if (n == 16) chk("wdt_out_p16", 32'(out_a), 32'h1);
      if (n == 24) chk("wdt_out_p24", 32'(out_a), 32'h7);
    end
    $display("watchdog coincident request done at %0t", $time);

    // Both requests held for 10 edges.
    sw_rst_req  = 1'b1;
    wdt_rst_req = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      chk("held_out", 32'(out_a), 32'h0);
    end
    sw_rst_req  = 1'b0;
    wdt_rst_req = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      step();
      if (n == 15) chk("held_out_e15", 32'(out_a), 32'h0);
      if (n == 16) chk("held_out_e16", 32'(out_a), 32'h1);
`ifdef RESET_SEQ_CAUSE_EN
      if (n == 16) chk("held_cause", 32'(cause_a), 32'h3);
`endif
    end
    $display("held simultaneous requests done at %0t", $time);

    // Randomized requests and occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      step();
      if (!async_in_rst) async_in_rst = 1'b1;
      else if ($urandom_range(0, 299) == 0) async_in_rst = 1'b0;
      sw_rst_req  = ($urandom_range(0, 59) == 0);
      wdt_rst_req = ($urandom_range(0, 59) == 0);
    end
    sw_rst_req  = 1'b0;
    wdt_rst_req = 1'b0;
    async_in_rst = 1'b1;
    repeat (30) step();
    $display("random phase done at %0t", $time);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
